// File: rtl/data_memory_unit.sv
// Load/store responder: serialises byte/halfword/word requests into little-endian byte
// transactions on a byte-wide RAM port, returning zero-extended loads or store acknowledges.
module data_memory_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_MASK_HI = 17
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  clearIn,
  input  logic [1:0]            accessType,
  input  logic                  readWriteIn,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]           dataWrite,
  output logic                  dataValid,
  output logic [31:0]           dataOut,
  output logic                  dataWriteSuc,
  output logic                  busy,
  input  logic [7:0]            memIn,
  output logic [7:0]            memOut,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWrite,
  input  logic                  ioBufferFull
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_out;
  logic                  r_wr_en;
  logic                  r_io;
  logic [31:0]           r_wdata;
  logic [31:0]           r_ld_buf;
  logic [31:0]           r_data_out;
  logic [1:0]            r_issue;
  logic [1:0]            r_cap;
  logic [1:0]            r_last;
  logic                  r_issuing;
  logic                  r_pend;
  logic                  r_valid;
  logic                  r_wsuc;
  logic                  r_busy;

  logic                  w_stall;
  logic [31:0]           w_ld_merged;

  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
    return (a[IO_MASK_HI -: 2] == 2'b11);
  endfunction

  function automatic logic [1:0] size_last(input logic [1:0] at);
    case (at)
      2'b01:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    return d[7:0];
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      2'd3:    return d[31:24];
      default: return 8'h00;
    endcase
  endfunction

  // IO stall gates the write strobe in the same cycle the buffer reports full.
  always_comb begin
    w_stall     = r_io & ioBufferFull;
    w_ld_merged = r_ld_buf;
    case (r_cap)
      2'd0:    w_ld_merged[7:0]   = memIn;
      2'd1:    w_ld_merged[15:8]  = memIn;
      2'd2:    w_ld_merged[23:16] = memIn;
      2'd3:    w_ld_merged[31:24] = memIn;
      default: w_ld_merged        = r_ld_buf;
    endcase
  end

  assign memWrite     = r_wr_en & ~w_stall;
  assign memAddr      = r_mem_addr;
  assign memOut       = r_mem_out;
  assign dataValid    = r_valid;
  assign dataWriteSuc = r_wsuc;
  assign dataOut      = r_data_out;
  assign busy         = r_busy;

  // Request sequencing: issue/capture pipeline for loads, stall-aware byte issue for stores.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_state    <= S_IDLE;
      r_mem_addr <= '0;
      r_mem_out  <= 8'h00;
      r_wr_en    <= 1'b0;
      r_io       <= 1'b0;
      r_wdata    <= 32'h0;
      r_ld_buf   <= 32'h0;
      r_data_out <= 32'h0;
      r_issue    <= 2'd0;
      r_cap      <= 2'd0;
      r_last     <= 2'd0;
      r_issuing  <= 1'b0;
      r_pend     <= 1'b0;
      r_valid    <= 1'b0;
      r_wsuc     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_wsuc  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (accessType != 2'b00) begin
            if (readWriteIn) begin
              // A flush in the same cycle kills a load before it starts.
              if (!clearIn) begin
                r_state    <= S_READ;
                r_busy     <= 1'b1;
                r_mem_addr <= dataAddr;
                r_issue    <= 2'd0;
                r_cap      <= 2'd0;
                r_issuing  <= 1'b1;
                r_pend     <= 1'b0;
                r_ld_buf   <= 32'h0;
                r_last     <= size_last(accessType);
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_state    <= S_WRITE;
              r_busy     <= 1'b1;
              r_mem_addr <= dataAddr;
              r_mem_out  <= dataWrite[7:0];
              r_wdata    <= dataWrite;
              r_wr_en    <= 1'b1;
              r_io       <= is_io(dataAddr);
              r_issue    <= 2'd0;
              r_last     <= size_last(accessType);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          if (clearIn) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_mem_addr <= '0;
            r_issuing  <= 1'b0;
            r_pend     <= 1'b0;
          end else begin
            r_pend <= r_issuing;
            if (r_issuing) begin
              if (r_issue == r_last) begin
                r_issuing <= 1'b0;
              end else begin
                r_issue    <= r_issue + 2'd1;
                r_mem_addr <= r_mem_addr + ADDR_ONE;
              end
            end else begin
              r_issuing <= 1'b0;
            end
            if (r_pend) begin
              r_ld_buf <= w_ld_merged;
              r_cap    <= r_cap + 2'd1;
              if (r_cap == r_last) begin
                r_data_out <= w_ld_merged;
                r_valid    <= 1'b1;
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_mem_addr <= '0;
              end else begin
                r_state <= S_READ;
              end
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_WRITE: begin
          // clearIn is deliberately ignored: a committed store must land.
          if (!w_stall) begin
            if (r_issue == r_last) begin
              r_state    <= S_IDLE;
              r_busy     <= 1'b0;
              r_wr_en    <= 1'b0;
              r_wsuc     <= 1'b1;
              r_mem_addr <= '0;
              r_mem_out  <= 8'h00;
              r_io       <= 1'b0;
            end else begin
              r_issue    <= r_issue + 2'd1;
              r_mem_addr <= r_mem_addr + ADDR_ONE;
              r_mem_out  <= byte_sel(r_wdata, r_issue + 2'd1);
              r_io       <= is_io(r_mem_addr + ADDR_ONE);
            end
          end else begin
            r_state <= S_WRITE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomised bench for data_memory_unit: a byte-array RAM model plus a reference memory
// predicting load values, store contents and request-to-pulse latencies.
module tb_data_memory_unit;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        clearIn;
  logic [1:0]  accessType;
  logic        readWriteIn;
  logic [31:0] dataAddr;
  logic [31:0] dataWrite;
  logic        dataValid;
  logic [31:0] dataOut;
  logic        dataWriteSuc;
  logic        busy;
  logic [7:0]  memIn;
  logic [7:0]  memOut;
  logic [31:0] memAddr;
  logic        memWrite;
  logic        ioBufferFull;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        ram_init;
  logic [31:0] last_load;

  data_memory_unit #(.ADDR_WIDTH(32), .IO_MASK_HI(17)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .clearIn(clearIn), .accessType(accessType),
    .readWriteIn(readWriteIn), .dataAddr(dataAddr), .dataWrite(dataWrite),
    .dataValid(dataValid), .dataOut(dataOut), .dataWriteSuc(dataWriteSuc), .busy(busy),
    .memIn(memIn), .memOut(memOut), .memAddr(memAddr), .memWrite(memWrite),
    .ioBufferFull(ioBufferFull)
  );

  always #5 clockIn = ~clockIn;

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    return a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic in_io(input logic [31:0] a);
    return (a[17:16] == 2'b11);
  endfunction

  // Byte-wide RAM: registered read (data one cycle after address), write on strobe.
  always @(posedge clockIn) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= seed_byte(32'(i));
    end else if (memWrite) begin
      ram[memAddr[15:0]] <= memOut;
    end
    memIn <= ram[memAddr[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request; entered and left at a negedge. clr_at: cycle offset of clearIn (-1 none).
  task automatic run_op(input logic rd, input logic [1:0] at, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall, input int clr_at);
    int          n;
    int          lat;
    int          wcnt;
    int          limit;
    bit          rd_wr;
    bit          dropped;
    bit          cleared;
    logic [31:0] exp_v;
    logic [31:0] a;
    logic [31:0] sh;
    n       = (at == 2'b01) ? 1 : (at == 2'b10) ? 2 : 4;
    lat     = -1;
    wcnt    = 0;
    rd_wr   = 1'b0;
    dropped = rd && (clr_at == 0);
    cleared = rd && (clr_at >= 1) && (clr_at <= n + 1);
    limit   = (dropped || cleared) ? 8 : 24;
    exp_v   = 32'h0;
    for (int i = 0; i < n; i++) begin
      a     = addr + 32'(i);
      exp_v = exp_v | (32'(ref_mem[a[15:0]]) << (8 * i));
    end
    accessType  = at;
    readWriteIn = rd;
    dataAddr    = addr;
    dataWrite   = wdata;
    clearIn     = (clr_at == 0);
    @(posedge clockIn); #1;
    accessType = 2'b00;
    dataWrite  = $urandom;
    dataAddr   = $urandom;
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) begin
        @(posedge clockIn); #1;
      end
      ioBufferFull = (k <= stall);
      clearIn      = (k == clr_at);
      @(negedge clockIn);
      if (k == 1) begin
        check("pulse_end", {30'h0, dataValid, dataWriteSuc}, 32'h0);
        check("busy_t1", {31'h0, busy}, {31'h0, !dropped});
      end
      if (rd && !dropped && k <= n && (!cleared || k <= clr_at))
        check("rd_addr", memAddr, addr + 32'(k - 1));
      if (memWrite) begin
        if (rd) rd_wr = 1'b1;
        else begin
          sh = wdata >> (8 * wcnt);
          check("wr_addr", memAddr, addr + 32'(wcnt));
          check("wr_data", {24'h0, memOut}, {24'h0, sh[7:0]});
        end
        wcnt++;
      end
      if (cleared && k == clr_at + 1) check("clr_busy", {31'h0, busy}, 32'h0);
      if ((dataValid || dataWriteSuc) && lat < 0) lat = k;
      if (lat > 0 && !(dropped || cleared)) break;
    end
    ioBufferFull = 1'b0;
    clearIn      = 1'b0;
    check("rd_no_write", {31'h0, rd_wr}, 32'h0);
    if (dropped || cleared) begin
      check("no_valid", 32'(lat), 32'hFFFF_FFFF);
      check("dout_kept", dataOut, last_load);
    end else begin
      check("busy_pulse", {31'h0, busy}, 32'h0);
      if (rd) begin
        check("ld_lat", 32'(lat), 32'(n + 2));
        check("ld_data", dataOut, exp_v);
        last_load = exp_v;
      end else begin
        check("st_lat", 32'(lat), 32'(n + 1 + (in_io(addr) ? stall : 0)));
        check("st_cnt", 32'(wcnt), 32'(n));
        for (int i = 0; i < n; i++) begin
          a  = addr + 32'(i);
          sh = wdata >> (8 * i);
          ref_mem[a[15:0]] = sh[7:0];
          check("st_mem", {24'h0, ram[a[15:0]]}, {24'h0, sh[7:0]});
        end
      end
    end
  endtask

  initial begin
    int          seen;
    logic [31:0] addr;
    logic [1:0]  at;
    logic        rd;
    int          clr;
    resetIn      = 1'b0;
    clearIn      = 1'b0;
    accessType   = 2'b00;
    readWriteIn  = 1'b0;
    dataAddr     = 32'h0;
    dataWrite    = 32'h0;
    ioBufferFull = 1'b0;
    ram_init     = 1'b1;
    last_load    = 32'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = seed_byte(32'(i));
    repeat (2) @(posedge clockIn);
    #1 ram_init = 1'b0;
    @(negedge clockIn);
    check("rst_outs", {dataValid, dataWriteSuc, busy, memWrite}, 32'h0);
    check("rst_dout", dataOut, 32'h0);
    check("rst_maddr", memAddr, 32'h0);
    check("rst_mout", {24'h0, memOut}, 32'h0);
    @(posedge clockIn); #1 resetIn = 1'b1;
    @(negedge clockIn);

    run_op(1'b0, 2'b01, 32'h0000_0100, 32'h0000_009A, 0, -1);
    run_op(1'b1, 2'b01, 32'h0000_0100, 32'h0, 0, -1);
    run_op(1'b0, 2'b11, 32'h0000_0FFE, 32'h4433_2211, 0, -1);
    run_op(1'b1, 2'b11, 32'h0000_0FFE, 32'h0, 0, -1);
    run_op(1'b0, 2'b10, 32'h0000_0200, 32'h0000_BEEF, 0, -1);
    run_op(1'b1, 2'b10, 32'h0000_0200, 32'h0, 0, -1);
    run_op(1'b0, 2'b01, 32'h0003_0000, 32'h0000_0041, 3, -1);
    run_op(1'b1, 2'b01, 32'h0003_0000, 32'h0, 5, -1);
    run_op(1'b1, 2'b11, 32'h0000_0FFE, 32'h0, 0, 2);
    run_op(1'b0, 2'b11, 32'h0000_0400, 32'h1234_5678, 0, 2);
    run_op(1'b1, 2'b01, 32'h0000_0400, 32'h0, 0, 0);
    run_op(1'b0, 2'b01, 32'h0000_0500, 32'h0000_00C3, 0, 0);
    run_op(1'b1, 2'b11, 32'hFFFF_FFFE, 32'h0, 0, -1);
    run_op(1'b0, 2'b11, 32'h0003_0010, 32'hA5B6_C7D8, 2, -1);

    for (int t = 0; t < 60; t++) begin
      rd = 1'($urandom);
      at = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 2))
        0:       addr = {16'h0000, 16'($urandom)};
        1:       addr = 32'h0003_0000 + 32'($urandom_range(0, 240));
        default: addr = 32'h0000_FF00 + 32'($urandom_range(0, 255));
      endcase
      clr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_op(rd, at, addr, $urandom, int'($urandom_range(0, 3)), clr);
    end

    accessType  = 2'b11;
    readWriteIn = 1'b1;
    dataAddr    = 32'h0000_0100;
    @(posedge clockIn); #1 accessType = 2'b00;
    @(posedge clockIn); #1 resetIn = 1'b0;
    #1;
    check("arst_outs", {dataValid, dataWriteSuc, busy, memWrite}, 32'h0);
    check("arst_dout", dataOut, 32'h0);
    check("arst_maddr", memAddr, 32'h0);
    @(posedge clockIn); #1 resetIn = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clockIn);
      if (dataValid || busy) seen++;
    end
    check("arst_no_pulse", 32'(seen), 32'h0);
    last_load = 32'h0;
    run_op(1'b1, 2'b01, 32'h0000_0100, 32'h0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
